// File: rtl/spi_seq_pkg.sv
// Shared types and defaults for the SPI burst sequencer.
package spi_seq_pkg;

  localparam int unsigned BUF_DEPTH_DEF = 64;
  localparam int unsigned ADDR_W_DEF    = 6;
  localparam int unsigned NUM_CS_DEF    = 4;

  // All chip selects deasserted; sliced to the configured NUM_CS
  localparam logic [31:0] CS_IDLE = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_FETCH,
    ST_LAUNCH,
    ST_WAIT,
    ST_WRBACK,
    ST_CS_HOLD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/spi_seq_ram.sv
// Single-port byte buffer: synchronous write, combinational read.
// The parent registers the read data, so reads appear one cycle after the address.
module spi_seq_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_c_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_c_o = mem_q[addr_i];

endmodule

// File: rtl/spi_sequencer.sv
// Multi-byte SPI burst sequencer: walks the byte buffer through the spimaster engine
// and writes each received byte back in place. Optional abort support: SPI_SEQ_ABORT_EN.
module spi_sequencer
  import spi_seq_pkg::*;
#(
  parameter  int unsigned BUF_DEPTH = BUF_DEPTH_DEF,
  parameter  int unsigned ADDR_W    = ADDR_W_DEF,
  parameter  int unsigned NUM_CS    = NUM_CS_DEF,
  localparam int unsigned LEN_W     = ADDR_W + 1,
  localparam int unsigned CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SPI_SEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  input  logic              start,
  input  logic [LEN_W-1:0]  xfer_len,
  input  logic [CS_W-1:0]   cs_index,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  byte_count,
  input  logic [ADDR_W-1:0] buf_addr,
  input  logic              buf_wr_en,
  input  logic [7:0]        buf_wdata,
  output logic [7:0]        buf_rdata,
  output logic [NUM_CS-1:0] cs_n,
  output logic              eng_xfer_start,
  output logic [7:0]        eng_tx_data,
  input  logic              eng_xfer_complete,
  input  logic [7:0]        eng_rx_data
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  byte_count_q, byte_count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer_start_q, xfer_start_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        rdata_q, rdata_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata, ram_rdata;
  logic              abort_now;
  logic              last_byte;

  // Host owns the buffer only in IDLE; otherwise the sequencer addresses it by idx
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = idx_q;
    ram_wdata = eng_rx_data;
    if (state_q == ST_IDLE) begin
      ram_we    = buf_wr_en;
      ram_addr  = buf_addr;
      ram_wdata = buf_wdata;
    end else if (state_q == ST_WRBACK) begin
      ram_we    = 1'b1;
    end
  end

  spi_seq_ram #(
    .DEPTH  (BUF_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .we_i      (ram_we),
    .addr_i    (ram_addr),
    .wdata_i   (ram_wdata),
    .rdata_c_o (ram_rdata)
  );

  assign last_byte = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_count_d = byte_count_q;
    idx_d        = idx_q;
    cs_n_d       = cs_n_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    xfer_start_d = 1'b0;
    tx_d         = tx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d       = 1'b1;
          idx_d        = '0;
          byte_count_d = '0;
          if (xfer_len == '0) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            len_d   = (xfer_len > LEN_W'(BUF_DEPTH)) ? LEN_W'(BUF_DEPTH) : xfer_len;
            cs_n_d  = CS_IDLE[NUM_CS-1:0] & ~(NUM_CS'(1) << cs_index);
            state_d = ST_CS_SETUP;
          end
        end
      end
      ST_CS_SETUP: state_d = abort_now ? ST_CS_HOLD : ST_FETCH;
      ST_FETCH: begin
        if (abort_now) begin
          state_d = ST_CS_HOLD;
        end else begin
          tx_d         = ram_rdata;
          xfer_start_d = 1'b1;
          state_d      = ST_LAUNCH;
        end
      end
      // The engine has already seen its start pulse, so the byte must be allowed to finish
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_xfer_complete) state_d = ST_WRBACK;
      end
      ST_WRBACK: begin
        idx_d        = idx_q + ADDR_W'(1);
        byte_count_d = byte_count_q + LEN_W'(1);
        state_d      = (last_byte || abort_now) ? ST_CS_HOLD : ST_FETCH;
      end
      ST_CS_HOLD: begin
        cs_n_d  = CS_IDLE[NUM_CS-1:0];
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rdata_d = (state_q == ST_IDLE && !busy_d) ? ram_rdata : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      byte_count_q <= '0;
      idx_q        <= '0;
      cs_n_q       <= CS_IDLE[NUM_CS-1:0];
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      xfer_start_q <= 1'b0;
      tx_q         <= 8'hFF;
      rdata_q      <= 8'h00;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_count_q <= byte_count_d;
      idx_q        <= idx_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      xfer_start_q <= xfer_start_d;
      tx_q         <= tx_d;
      rdata_q      <= rdata_d;
    end
  end

`ifdef SPI_SEQ_ABORT_EN
  logic abort_pend_q, abort_pend_d;
  logic aborted_q, aborted_d;

  assign abort_now = abort | abort_pend_q;

  // Remember an abort for the rest of the burst; report it once the burst has ended
  always_comb begin
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;
    case (state_q)
      ST_IDLE:    if (start) aborted_d = 1'b0;
      ST_CS_SETUP, ST_FETCH, ST_LAUNCH, ST_WAIT, ST_WRBACK: abort_pend_d = abort_now;
      ST_CS_HOLD: aborted_d = abort_pend_q;
      ST_DONE:    abort_pend_d = 1'b0;
      default:    abort_pend_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
    end
  end

  assign aborted = aborted_q;
`else
  assign abort_now = 1'b0;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign byte_count     = byte_count_q;
  assign buf_rdata      = rdata_q;
  assign cs_n           = cs_n_q;
  assign eng_xfer_start = xfer_start_q;
  assign eng_tx_data    = tx_q;

endmodule

// File: tb/tb_spi_sequencer.sv
// Directed bench for spi_sequencer with a looping, inverting engine model.
// Define SPI_SEQ_ABORT_EN to also exercise the abort path.
module tb_spi_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] xfer_len = '0;
  logic [1:0] cs_index = '0;
  logic       busy, done;
  logic [6:0] byte_count;
  logic [5:0] buf_addr = '0;
  logic       buf_wr_en = 1'b0;
  logic [7:0] buf_wdata = '0;
  logic [7:0] buf_rdata;
  logic [3:0] cs_n;
  logic       eng_xfer_start;
  logic [7:0] eng_tx_data;
  logic       eng_xfer_complete;
  logic [7:0] eng_rx_data;
`ifdef SPI_SEQ_ABORT_EN
  logic       abort = 1'b0;
  logic       aborted;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
`ifdef SPI_SEQ_ABORT_EN
    .abort             (abort),
    .aborted           (aborted),
`endif
    .start             (start),
    .xfer_len          (xfer_len),
    .cs_index          (cs_index),
    .busy              (busy),
    .done              (done),
    .byte_count        (byte_count),
    .buf_addr          (buf_addr),
    .buf_wr_en         (buf_wr_en),
    .buf_wdata         (buf_wdata),
    .buf_rdata         (buf_rdata),
    .cs_n              (cs_n),
    .eng_xfer_start    (eng_xfer_start),
    .eng_tx_data       (eng_tx_data),
    .eng_xfer_complete (eng_xfer_complete),
    .eng_rx_data       (eng_rx_data)
  );

  // Engine model: no reset, returns the inverted TX byte a few cycles after start
  logic       model_active = 1'b0;
  int         model_cnt = 0;
  logic [7:0] model_lat = '0;
  logic       model_cmp = 1'b0;
  logic [7:0] model_rx = '0;
  logic       stray_cmp = 1'b0;
  logic [7:0] stray_rx = '0;

  always @(posedge clk) begin
    model_cmp <= 1'b0;
    if (eng_xfer_start) begin
      model_active <= 1'b1;
      model_cnt    <= 4;
      model_lat    <= ~eng_tx_data;
    end else if (model_active) begin
      if (model_cnt == 0) begin
        model_cmp    <= 1'b1;
        model_rx     <= model_lat;
        model_active <= 1'b0;
      end else begin
        model_cnt <= model_cnt - 1;
      end
    end
  end

  assign eng_xfer_complete = model_cmp | stray_cmp;
  assign eng_rx_data       = stray_cmp ? stray_rx : model_rx;

  // Monitor: logs engine handshakes, done pulses and chip-select violations
  int         cyc = 0, n_start = 0, n_cmp = 0, n_done = 0, cs_bad = 0;
  int         last_cmp = 0, last_done = 0;
  logic [7:0] tx_log [256];
  int         start_cyc [256];
  int         cmp_cyc [256];
  logic [3:0] cs_expect = 4'hF;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (eng_xfer_start) begin
      tx_log[8'(n_start)]    <= eng_tx_data;
      start_cyc[8'(n_start)] <= cyc;
      n_start                <= n_start + 1;
    end
    if (eng_xfer_complete) begin
      cmp_cyc[8'(n_cmp)] <= cyc;
      n_cmp              <= n_cmp + 1;
      last_cmp           <= cyc;
    end
    if (done) begin
      n_done    <= n_done + 1;
      last_done <= cyc;
    end
    if (cs_n != 4'hF && cs_n != cs_expect) cs_bad <= cs_bad + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    buf_addr = a; buf_wdata = d; buf_wr_en = 1'b1;
    @(posedge clk); #1;
    buf_wr_en = 1'b0;
  endtask

  task automatic host_read(input logic [5:0] a, output logic [7:0] d);
    buf_addr = a;
    @(posedge clk); #1;
    d = buf_rdata;
  endtask

  task automatic pulse_start(input logic [6:0] len, input logic [1:0] cs);
    xfer_len = len; cs_index = cs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    @(posedge clk); @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (eng_xfer_start !== 1'b0) begin bad++; $display("FAIL reset_xstart got=%b want=0", eng_xfer_start); end
    total++; if (cs_n !== 4'hF) begin bad++; $display("FAIL reset_cs_n got=%b want=1111", cs_n); end
    total++; if (eng_tx_data !== 8'hFF) begin bad++; $display("FAIL reset_tx got=%h want=ff", eng_tx_data); end
    total++; if (byte_count !== 7'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", byte_count); end
    total++; if (buf_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h want=00", buf_rdata); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [7:0] pat [4];
    logic [7:0] r;
    int s0, c0, d0, cb0, errs;
    bit ok;
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hFF; pat[3] = 8'h00;
    for (int i = 0; i < 4; i++) host_write(6'(i), pat[i]);
    s0 = n_start; c0 = n_cmp; d0 = n_done; cb0 = cs_bad;
    cs_expect = 4'b1011;
    pulse_start(7'd4, 2'd2);
    total++; if (cs_n !== 4'b1011) begin bad++; $display("FAIL basic_cs_cycle1 got=%b want=1011", cs_n); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_cycle1 got=%b want=1", busy); end
    @(posedge clk); #1;
    total++; if (eng_xfer_start !== 1'b0) begin bad++; $display("FAIL basic_xstart_cycle2 got=%b want=0", eng_xfer_start); end
    total++; if (buf_rdata !== 8'h00) begin bad++; $display("FAIL basic_rdata_busy got=%h want=00", buf_rdata); end
    @(posedge clk); #1;
    total++; if (eng_xfer_start !== 1'b1) begin bad++; $display("FAIL basic_xstart_cycle3 got=%b want=1", eng_xfer_start); end
    total++; if (eng_tx_data !== 8'hA5) begin bad++; $display("FAIL basic_tx_cycle3 got=%h want=a5", eng_tx_data); end
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout got=none want=done"); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    total++; if (last_done - last_cmp !== 3) begin bad++; $display("FAIL basic_done_latency got=%0d want=3", last_done - last_cmp); end
    total++; if (start_cyc[8'(s0 + 1)] - cmp_cyc[8'(c0)] !== 3) begin bad++; $display("FAIL basic_gap got=%0d want=3", start_cyc[8'(s0 + 1)] - cmp_cyc[8'(c0)]); end
    total++; if (n_start - s0 !== 4) begin bad++; $display("FAIL basic_starts got=%0d want=4", n_start - s0); end
    errs = 0;
    for (int k = 0; k < 4; k++) if (tx_log[8'(s0 + k)] !== pat[k]) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL basic_tx_order got=%0d_wrong want=0_wrong", errs); end
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", n_done - d0); end
    total++; if (cs_bad !== cb0) begin bad++; $display("FAIL basic_cs_select got=%0d_bad want=0_bad", cs_bad - cb0); end
    total++; if (byte_count !== 7'd4) begin bad++; $display("FAIL basic_count got=%0d want=4", byte_count); end
    for (int k = 0; k < 4; k++) begin
      host_read(6'(k), r);
      total++; if (r !== ~pat[k]) begin bad++; $display("FAIL basic_readback[%0d] got=%h want=%h", k, r, ~pat[k]); end
    end
  endtask

  task automatic test_zero_len;
    int s0, d0;
    s0 = n_start; d0 = n_done;
    pulse_start(7'd0, 2'd1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done_cycle1 got=%b want=1", done); end
    total++; if (cs_n !== 4'hF) begin bad++; $display("FAIL zero_cs_n got=%b want=1111", cs_n); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_after got=%b want=0", busy); end
    repeat (8) @(posedge clk); #1;
    total++; if (n_start !== s0) begin bad++; $display("FAIL zero_no_engine got=%0d want=0", n_start - s0); end
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL zero_done_count got=%0d want=1", n_done - d0); end
    total++; if (byte_count !== 7'd0) begin bad++; $display("FAIL zero_count got=%0d want=0", byte_count); end
  endtask

  task automatic test_clamp;
    logic [7:0] r;
    int s0, errs;
    bit ok;
    for (int i = 0; i < 64; i++) host_write(6'(i), 8'(i * 3 + 1));
    s0 = n_start;
    cs_expect = 4'b0111;
    pulse_start(7'd100, 2'd3);
    wait_done(1500, ok);
    total++; if (!ok) begin bad++; $display("FAIL clamp_done_timeout got=none want=done"); end
    @(posedge clk); #1;
    total++; if (n_start - s0 !== 64) begin bad++; $display("FAIL clamp_starts got=%0d want=64", n_start - s0); end
    total++; if (byte_count !== 7'd64) begin bad++; $display("FAIL clamp_count got=%0d want=64", byte_count); end
    errs = 0;
    for (int k = 0; k < 64; k++) if (tx_log[8'(s0 + k)] !== 8'(k * 3 + 1)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL clamp_tx_order got=%0d_wrong want=0_wrong", errs); end
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      host_read(6'(k), r);
      if (r !== ~8'(k * 3 + 1)) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL clamp_readback got=%0d_wrong want=0_wrong", errs); end
  endtask

  task automatic test_busy_block;
    logic [7:0] r;
    int s0, d0, zero_errs;
    bit ok;
    host_write(6'd0, 8'h11);
    host_write(6'd1, 8'h22);
    s0 = n_start; d0 = n_done;
    cs_expect = 4'b1110;
    pulse_start(7'd2, 2'd0);
    buf_addr = 6'd0; buf_wdata = 8'h77; buf_wr_en = 1'b1;
    @(posedge clk); #1;
    buf_wr_en = 1'b0;
    pulse_start(7'd4, 2'd1);
    zero_errs = 0;
    for (int i = 0; i < 6; i++) begin
      if (buf_rdata !== 8'h00) zero_errs++;
      @(posedge clk); #1;
    end
    total++; if (zero_errs !== 0) begin bad++; $display("FAIL busy_rdata_zero got=%0d_nonzero want=0_nonzero", zero_errs); end
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_done_timeout got=none want=done"); end
    repeat (15) @(posedge clk); #1;
    total++; if (n_start - s0 !== 2) begin bad++; $display("FAIL busy_starts got=%0d want=2", n_start - s0); end
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL busy_done_count got=%0d want=1", n_done - d0); end
    host_read(6'd0, r);
    total++; if (r !== 8'hEE) begin bad++; $display("FAIL busy_addr0 got=%h want=ee", r); end
    host_read(6'd1, r);
    total++; if (r !== 8'hDD) begin bad++; $display("FAIL busy_addr1 got=%h want=dd", r); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] r;
    int s0, d0;
    host_write(6'd0, 8'h42);
    s0 = n_start; d0 = n_done;
    cs_expect = 4'b1101;
    pulse_start(7'd2, 2'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (cs_n !== 4'hF) begin bad++; $display("FAIL rstmid_cs_n got=%b want=1111", cs_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray_rx = 8'h99; stray_cmp = 1'b1;
    @(posedge clk); #1;
    stray_cmp = 1'b0;
    repeat (12) @(posedge clk); #1;
    total++; if (n_done !== d0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", n_done - d0); end
    total++; if (n_start - s0 !== 1) begin bad++; $display("FAIL rstmid_starts got=%0d want=1", n_start - s0); end
    total++; if (busy !== 1'b0 || byte_count !== 7'd0) begin bad++; $display("FAIL rstmid_idle got=busy%b_cnt%0d want=busy0_cnt0", busy, byte_count); end
    host_read(6'd0, r);
    total++; if (r !== 8'h42) begin bad++; $display("FAIL rstmid_no_write got=%h want=42", r); end
  endtask

`ifdef SPI_SEQ_ABORT_EN
  task automatic test_abort;
    logic [7:0] r;
    int s0;
    bit ok;
    for (int i = 0; i < 8; i++) host_write(6'(i), 8'(8'h10 + i));
    s0 = n_start;
    cs_expect = 4'b1101;
    pulse_start(7'd8, 2'd1);
    for (int i = 0; i < 100 && n_start - s0 < 3; i++) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_done_timeout got=none want=done"); end
    @(posedge clk); #1;
    total++; if (byte_count !== 7'd3) begin bad++; $display("FAIL abort_count got=%0d want=3", byte_count); end
    total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort_flag got=%b want=1", aborted); end
    total++; if (last_done - last_cmp !== 3) begin bad++; $display("FAIL abort_done_latency got=%0d want=3", last_done - last_cmp); end
    total++; if (n_start - s0 !== 3) begin bad++; $display("FAIL abort_starts got=%0d want=3", n_start - s0); end
    host_read(6'd2, r);
    total++; if (r !== 8'hED) begin bad++; $display("FAIL abort_byte2 got=%h want=ed", r); end
    host_read(6'd3, r);
    total++; if (r !== 8'h13) begin bad++; $display("FAIL abort_byte3 got=%h want=13", r); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_clamp();
    test_busy_block();
    test_reset_mid();
`ifdef SPI_SEQ_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_sequencer.md
# spi_sequencer

Multi-byte SPI transfer sequencer. It owns a byte buffer that the host preloads with TX bytes, drives the byte-level `spimaster` engine once per byte, and overwrites each TX byte in place with the received byte. It also generates the chip selects around the whole burst. It sits between the memory-mapped SPI controller and `spimaster`.

## Interface
Parameters:
- `BUF_DEPTH`, 64: buffer size in bytes; must be a power of two.
- `ADDR_W`, 6: log2(`BUF_DEPTH`).
- `NUM_CS`, 4: number of chip-select outputs.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle burst request.
- `xfer_len` in `ADDR_W+1`: byte count, sampled on `start`.
- `cs_index` in `$clog2(NUM_CS)`: target device, sampled on `start`.
- `busy` out 1: high from the accepted `start` until `done`, inclusive.
- `done` out 1: single-cycle pulse when the burst has ended.
- `byte_count` out `ADDR_W+1`: bytes completed in the current/last burst.
- `buf_addr` in `ADDR_W`: host buffer address.
- `buf_wr_en` in 1: host write strobe.
- `buf_wdata` in 8: host write data.
- `buf_rdata` out 8: host read data.
- `cs_n` out `NUM_CS`: active-low chip selects.
- `eng_xfer_start` out 1: to `spimaster` `xfer_start`.
- `eng_tx_data` out 8: to `spimaster` `tx_data`.
- `eng_xfer_complete` in 1: from `spimaster` `xfer_complete`.
- `eng_rx_data` in 8: from `spimaster` `rx_data`.

## Operation
- States: IDLE, CS_SETUP, FETCH, LAUNCH, WAIT, WRBACK, CS_HOLD, DONE.
- IDLE → CS_SETUP on `start` when `xfer_len` != 0.
  - Latches `len` = min(`xfer_len`, `BUF_DEPTH`) and `cs_index`.
  - Clears `idx` and `byte_count`.
- `start` with `xfer_len` == 0: go straight to DONE. No chip select, no engine activity.
- CS_SETUP: drive `cs_n[cs_index]` low; all other chip selects stay high → FETCH.
- FETCH: read the buffer at `idx` → LAUNCH.
- LAUNCH:
  - Register the read data into `eng_tx_data`.
  - Pulse `eng_xfer_start` for exactly one cycle → WAIT.
- WAIT: hold `eng_tx_data` stable; stay until `eng_xfer_complete` → WRBACK.
- WRBACK:
  - Write `eng_rx_data` to the buffer at `idx`; increment `idx` and `byte_count`.
  - If `idx+1` == `len` → CS_HOLD, else → FETCH.
- CS_HOLD: one cycle with the chip select still low → DONE.
- DONE: release all chip selects, pulse `done` → IDLE.
- Byte order: buffer index 0 goes first. Bit order within a byte is the engine's concern.
- Host buffer port:
  - In IDLE: reads are synchronous with 1-cycle latency; writes land on the clock edge.
  - While `busy`: host writes are dropped and `buf_rdata` reads 8'h00.
- `start` while `busy` is ignored.
- `eng_xfer_complete` outside WAIT is ignored. This covers a stray pulse after a reset mid-byte, because the engine has no reset.
- Reset values:
  - `busy`, `done`, `eng_xfer_start` = 0.
  - `cs_n` all 1.
  - `eng_tx_data` = 8'hFF.
  - `byte_count` = 0.
  - `buf_rdata` = 0.
  - State = IDLE.
  - Buffer contents are not reset.

## Timing
- `start` at cycle 0 → `cs_n` low at cycle 1 → `eng_xfer_start` high at cycle 3.
- Inter-byte gap: `eng_xfer_complete` at cycle N → next `eng_xfer_start` at N+3 (WRBACK, FETCH, LAUNCH). This gap is ≥ the engine's return-to-idle time.
- Last `eng_xfer_complete` at cycle N:
  - `cs_n` released at N+3.
  - `done` asserted at N+3.
  - `busy` low at N+4.
- `byte_count` updates in the cycle after WRBACK.

## Configuration
- Macro `SPI_SEQ_ABORT_EN` defined:
  - Adds input `abort` and output `aborted`.
  - `abort` in CS_SETUP, FETCH or LAUNCH-pending jumps to CS_HOLD.
  - `abort` in WAIT completes the in-flight byte first (WRBACK is still performed), then goes to CS_HOLD.
  - `aborted` is held high from DONE until the next accepted `start`. Its reset value is 0.
  - `byte_count` reflects only the completed bytes.
- Macro not defined: neither port exists, and every burst runs to `len`.

## Structure
- Package `spi_seq_pkg`: state enum, default `BUF_DEPTH`/`ADDR_W`, and a `CS_IDLE` constant (all ones).
- Sub-module `spi_seq_ram`: single-port synchronous RAM, `BUF_DEPTH`×8. The address/data/write-enable mux between host and sequencer lives in the parent.

## Test plan
- Preload buffer 0..3 = A5,3C,FF,00. Engine model loops MOSI→MISO with inverted bytes. `start`, `xfer_len`=4, `cs_index`=2 → `cs_n`=1011 for the whole burst, and four `eng_xfer_start` pulses with `eng_tx_data` = A5,3C,FF,00. Buffer reads back 5A,C3,00,FF; `byte_count`=4; one `done`.
- `xfer_len`=0 → `done` at cycle 1, `cs_n` stays 1111, no `eng_xfer_start`.
- `xfer_len`=100 with `BUF_DEPTH`=64 → exactly 64 bytes transferred, `byte_count`=64, `idx` wrap never observed.
- Host write to addr 0 and `start` during `busy` → buffer unchanged, no second burst, `buf_rdata`=00 while `busy`.
- Assert `rst_n` during WAIT, then inject a stray `eng_xfer_complete` → `cs_n`=1111 immediately, state IDLE, no `done`, no buffer write.
- `SPI_SEQ_ABORT_EN`: `abort` during byte 2 of 8 → byte 2 is written back, `byte_count`=3, `aborted`=1, `done` at N+3.
